font_writer: RTL

//  Host-side write engine for the 4096x16 font BRAM write port (wr_en/wr_address/wr_data).

---
 rtl/font_writer_pkg.sv | 19 +
 rtl/font_writer_if.sv | 28 ++
 rtl/font_cmd_fifo.sv | 57 +++++
 rtl/font_writer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/font_writer_pkg.sv
// Shared types and widths for the font BRAM write engine.
package font_writer_pkg;

    localparam int unsigned FONT_ADDR_W = 12;
    localparam int unsigned FONT_DATA_W = 16;

    typedef enum logic [1:0] {
        FONT_CMD_SET_ADDR = 2'd0,
        FONT_CMD_SET_INCR = 2'd1,
        FONT_CMD_WRITE    = 2'd2,
        FONT_CMD_FILL     = 2'd3
    } font_cmd_t;

    typedef enum logic {
        FW_IDLE = 1'b0,
        FW_FILL = 1'b1
    } fw_state_t;

endpackage

// File: rtl/font_writer_if.sv
// Command handshake and font BRAM write-port bundle for font_writer.
interface font_writer_if
    import font_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = FONT_ADDR_W,
    parameter int unsigned DATA_W = FONT_DATA_W
) ();

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    font_cmd_t         cmd_type_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_address_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              busy_o;

    modport master (
        output cmd_valid_i, cmd_type_i, cmd_data_i,
        input  cmd_ready_o, wr_en_o, wr_address_o, wr_data_o, busy_o
    );

    modport slave (
        input  cmd_valid_i, cmd_type_i, cmd_data_i,
        output cmd_ready_o, wr_en_o, wr_address_o, wr_data_o, busy_o
    );

endinterface

// File: rtl/font_cmd_fifo.sv
// Small synchronous command FIFO with full/empty flags and a flush input.
module font_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 18
) (
    input  logic         clk,
    input  logic         reset_n_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Pointer and occupancy tracking; flush empties the queue.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/font_writer.sv
// Font BRAM write engine: queued SET_ADDR/SET_INCR/WRITE/FILL commands,
// at most one font word write per clk.
// Optional macro FONT_WRITER_ABORT_EN adds abort_i (flush FIFO, stop fill).
module font_writer
    import font_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = FONT_ADDR_W,
    parameter int unsigned DATA_W     = FONT_DATA_W
) (
    input  logic         clk,
    input  logic         reset_n_i,
`ifdef FONT_WRITER_ABORT_EN
    input  logic         abort_i,
`endif
    font_writer_if.slave bus
);

    localparam int unsigned ENTRY_W = 2 + DATA_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_FILL = {1'b1, {ADDR_W{1'b0}}};

    fw_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  incr_q, incr_d;
    logic [DATA_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic               full, empty, push, pop, abort_c;
    logic [ENTRY_W-1:0] head;
    font_cmd_t          head_type;
    logic [DATA_W-1:0]  head_data;
    logic [CNT_W-1:0]   fill_req, fill_n;

`ifdef FONT_WRITER_ABORT_EN
    assign abort_c = abort_i;
`else
    assign abort_c = 1'b0;
`endif

    assign push      = bus.cmd_valid_i & ~full & ~abort_c;
    assign head_type = font_cmd_t'(head[ENTRY_W-1 -: 2]);
    assign head_data = head[DATA_W-1:0];
    assign fill_req  = head_data[ADDR_W:0];
    assign fill_n    = (fill_req > MAX_FILL) ? MAX_FILL : fill_req;

    font_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (abort_c),
        .data_i    ({bus.cmd_type_i, bus.cmd_data_i}),
        .data_o    (head),
        .full_o    (full),
        .empty_o   (empty)
    );

    // State, pointer registers and registered write port.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= FW_IDLE;
            addr_q    <= '0;
            incr_q    <= ADDR_W'(1);
            last_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            incr_q    <= incr_d;
            last_q    <= last_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Command decode and fill sequencing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        incr_d    = incr_q;
        last_d    = last_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pop       = 1'b0;

        unique case (state_q)
            FW_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    case (head_type)
                        FONT_CMD_SET_ADDR: addr_d = head_data[ADDR_W-1:0];
                        FONT_CMD_SET_INCR: incr_d = head_data[ADDR_W-1:0];
                        FONT_CMD_WRITE: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = head_data;
                            last_d    = head_data;
                            addr_d    = addr_q + incr_q;
                        end
                        FONT_CMD_FILL: begin
                            if (fill_n != '0) begin
                                count_d = fill_n;
                                state_d = FW_FILL;
                            end
                        end
                    endcase
                end
            end
            FW_FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = last_q;
                addr_d    = addr_q + incr_q;
                count_d   = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) state_d = FW_IDLE;
            end
            default: state_d = FW_IDLE;
        endcase

        // Abort cancels whatever this cycle would have done; pointers keep their values.
        if (abort_c) begin
            state_d   = FW_IDLE;
            addr_d    = addr_q;
            incr_d    = incr_q;
            last_d    = last_q;
            count_d   = '0;
            wr_en_d   = 1'b0;
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
            pop       = 1'b0;
        end
    end

    assign bus.cmd_ready_o  = ~full;
    assign bus.wr_en_o      = wr_en_q;
    assign bus.wr_address_o = wr_addr_q;
    assign bus.wr_data_o    = wr_data_q;
    assign bus.busy_o       = ~empty | (state_q == FW_FILL) | wr_en_q;

endmodule
